axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-port AXI read arbiter that lets two read masters share the single memory-side read port in front of `axi_ram`. Typical masters are a `prefetcherTop` instance and a bypass path, or two prefetchers. AR requests are granted round-robin and issued through a registered AR stage. Because the memory returns read bursts in order, each grant is recorded in an in-order tracking FIFO, and R beats are steered back to the owning port by the FIFO head.

## Interface
Parameters:
- ADDR_BITS, 64, AR address width
- BURST_LEN_WIDTH, 8, AR len width
- TID_WIDTH, 8, AR/R id width
- LOG_BLOCK_DATA_BYTES, 0, R data width = 8<<LOG_BLOCK_DATA_BYTES bits
- LOG_OUTSTANDING, 2, tracking FIFO depth = 2**LOG_OUTSTANDING bursts

Ports (sN = s0, s1; each port exists for both):
- clk  in  1  single clock, all logic on rising edge
- resetN  in  1  synchronous, active-low reset
- en  in  1  0 = no new grants; in-flight bursts complete
- sN_ar_valid / sN_ar_ready  in / out  1 / 1  requester AR handshake
- sN_ar_addr / sN_ar_len / sN_ar_id  in  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  requester AR payload
- m_ar_valid / m_ar_ready  out / in  1 / 1  memory AR handshake
- m_ar_addr / m_ar_len / m_ar_id  out  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  registered AR payload
- m_r_valid / m_r_ready  in / out  1 / 1  memory R handshake
- m_r_data / m_r_last / m_r_id  in  DATA_WIDTH / 1 / TID_WIDTH  memory R payload
- sN_r_valid / sN_r_ready  out / in  1 / 1  requester R handshake
- sN_r_data / sN_r_last / sN_r_id  out  DATA_WIDTH / 1 / TID_WIDTH  R payload, passed through from m_r_*
- outstandingCnt  out  LOG_OUTSTANDING+1  occupancy of the tracking FIFO
- errUnexpected  out  1  sticky flag: an R beat arrived while no burst was outstanding

## Operation
- AR state machine has two states, ARB_IDLE and ARB_ISSUE.
- ARB_IDLE: a grant happens when en=1, outstandingCnt < depth and at least one sN_ar_valid=1.
  - Winner: the port named by rrPtr if that port is valid, otherwise the other port.
  - sN_ar_ready of the winner is driven combinationally high in the same cycle; the loser's ready stays 0.
  - The winner's addr/len/id are captured into the m_ar registers.
  - Next state is ARB_ISSUE.
- ARB_ISSUE: m_ar_valid=1 and the m_ar payload is held stable until m_ar_ready=1. On that handshake:
  - the granted port index is pushed into the FIFO;
  - rrPtr is set to the other port;
  - next state is ARB_IDLE.
- R routing (combinational):
  - sel = FIFO head; active only when the FIFO is non-empty.
  - sN_r_valid = m_r_valid & nonEmpty & (sel==N).
  - m_r_ready = nonEmpty & s{sel}_r_ready.
- FIFO pop: on m_r_valid & m_r_ready & m_r_last.
- Push and pop in the same cycle: both take effect and outstandingCnt is unchanged.
- Unexpected R beat (m_r_valid with the FIFO empty): m_r_ready stays 0, the beat is not consumed, and errUnexpected is set. errUnexpected clears only on reset.
- en falling while in ARB_ISSUE: the pending AR still completes and R beats keep draining.

## Timing
- Reset (resetN=0 at a rising edge):
  - state = ARB_IDLE, rrPtr = 0, FIFO empty.
  - Every output is 0: all ready and valid signals, m_ar payload, outstandingCnt, errUnexpected.
  - sN_r data/last/id mirror m_r_* and are don't-care while valid=0.
- Reset asserted mid-burst: tracking is discarded; the bench must also reset the memory.
- AR latency: sN_ar_ready is high in cycle T; m_ar_valid is high from T+1.
- Peak AR throughput: one grant every 2 cycles when m_ar_ready is tied high.
- R path: zero latency, no buffering.
- Full: with outstandingCnt == depth, no grant is made. A pop in cycle T allows a grant in T+1, not in T.
- rrPtr changes only on a completed m_ar handshake. A port that holds valid is therefore granted within 2 grants.

## Structure
- Package axi_arb_pkg holds:
  - typedef arb_st_t {ARB_IDLE, ARB_ISSUE};
  - typedef port_idx_t (1 bit);
  - constants for port 0 and port 1.
- Sub-module axi_rd_order_fifo: synchronous FIFO of port_idx_t, depth 2**LOG_OUTSTANDING.
  - Ports: push, pop, head, empty, full, count.
  - Push and pop in the same cycle are legal when full.
- FSM, AR registers and R steering live in the top module.

## Test plan
- Single request: s0 AR addr=0x10, len=3, id=5, m_ar_ready=1 → s0_ar_ready in cycle T, m_ar_valid in T+1 with 0x10/3/5; 4 beats appear on s0_r, last on beat 4; s1_r_valid stays 0; outstandingCnt goes 0→1→0.
- Contention: s0 and s1 held valid from reset → grant order s0, s1, s0, s1; R bursts return in that order to the matching ports.
- Backpressure: m_ar_ready=0 for 5 cycles → m_ar payload stable and no further grants; s1_r_ready=0 during an s1 burst → m_r_ready=0 and no beats are lost.
- Full: depth 4 with R withheld → 4 grants, then sN_ar_ready stays 0; the first m_r_last pop allows a grant the following cycle.
- Error/enable:
  - m_r_valid with the FIFO empty → errUnexpected=1 and sticky until resetN=0.
  - en=0 with requests pending → no grants; an in-flight burst still delivers all beats.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types for the two-port AXI read arbiter:
//   arb_st_t   - AR grant state machine encoding
//   port_idx_t - index of a requester port (0 or 1)
//   PORT0/1    - named port indices
//   other_port - the port that is not p (round-robin advance)
// ----------------------------------------------------------------------------
package axi_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_ISSUE = 1'b1
   } arb_st_t;

   typedef logic port_idx_t;

   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

   function automatic port_idx_t other_port(input port_idx_t p);
      return ~p;
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter_if
// One AXI read channel pair (AR + R).
//   master modport: drives ar_valid/ar_addr/ar_len/ar_id and r_ready
//   slave  modport: drives ar_ready and r_valid/r_data/r_last/r_id
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge; ready may be raised or lowered freely and may depend
// combinationally on valid.
// ----------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
   parameter int ADDR_BITS       = 64,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int TID_WIDTH       = 8,
   parameter int DATA_WIDTH      = 8
);

   logic                       ar_valid;
   logic                       ar_ready;
   logic [ADDR_BITS-1:0]       ar_addr;
   logic [BURST_LEN_WIDTH-1:0] ar_len;
   logic [TID_WIDTH-1:0]       ar_id;

   logic                       r_valid;
   logic                       r_ready;
   logic [DATA_WIDTH-1:0]      r_data;
   logic                       r_last;
   logic [TID_WIDTH-1:0]       r_id;

   modport master (
      output ar_valid, ar_addr, ar_len, ar_id, r_ready,
      input  ar_ready, r_valid, r_data, r_last, r_id
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len, ar_id, r_ready,
      output ar_ready, r_valid, r_data, r_last, r_id
   );

endinterface

// File: rtl/axi_rd_order_fifo.sv
// ----------------------------------------------------------------------------
// axi_rd_order_fifo
// Records which requester owns each outstanding read burst, in issue order.
// Ports:
//   clk, resetN  - clock, synchronous active-low reset
//   push, din    - append the granted port index
//   pop          - retire the head entry (last R beat delivered)
//   head         - port index of the oldest outstanding burst
//   empty, full  - occupancy flags
//   count        - number of stored entries (0 .. 2**LOG_DEPTH)
// A push while full is accepted when a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module axi_rd_order_fifo
   import axi_arb_pkg::*;
#(
   parameter int LOG_DEPTH = 2
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             push,
   input  port_idx_t        din,
   input  logic             pop,
   output port_idx_t        head,
   output logic             empty,
   output logic             full,
   output logic [LOG_DEPTH:0] count
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int PW    = (LOG_DEPTH > 0) ? LOG_DEPTH : 1;
   localparam int CW    = LOG_DEPTH + 1;

   port_idx_t       mem_q [DEPTH];
   port_idx_t       mem_d [DEPTH];
   logic [PW-1:0]   wr_q, wr_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok;
   logic            pop_ok;

   // Explicit wrap so non-power-of-two pointer widths (depth 1) still work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign head  = mem_q[rd_q];
   assign count = count_q;

   always_comb begin
      push_ok = push & (~full | pop);
      pop_ok  = pop & ~empty;
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_ok) begin
         mem_d[wr_q] = din;
         wr_d        = next_ptr(wr_q);
      end
      if (pop_ok) begin
         rd_d = next_ptr(rd_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= PORT0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
// Lets two AXI read masters share one memory-side read port.
// Ports:
//   clk, resetN     - clock, synchronous active-low reset
//   en              - 0 blocks new AR grants; in-flight traffic completes
//   s0, s1          - requester channels (arbiter is the slave side)
//   m               - memory channel (arbiter is the master side)
//   outstandingCnt  - bursts issued to memory whose last beat has not returned
//   errUnexpected   - sticky: an R beat showed up with nothing outstanding
//   dbg_state       - current AR state machine state
// AR requests are granted round-robin and issued from registers one cycle
// later. Memory returns bursts in order, so a FIFO of granted port indices
// steers each R beat to its owner with no buffering.
// ----------------------------------------------------------------------------
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_BITS            = 64,
   parameter int BURST_LEN_WIDTH      = 8,
   parameter int TID_WIDTH            = 8,
   parameter int LOG_BLOCK_DATA_BYTES = 0,
   parameter int LOG_OUTSTANDING      = 2
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     en,
   axi_rd_arbiter_if.slave          s0,
   axi_rd_arbiter_if.slave          s1,
   axi_rd_arbiter_if.master         m,
   output logic [LOG_OUTSTANDING:0] outstandingCnt,
   output logic                     errUnexpected,
   output arb_st_t                  dbg_state
);

   localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;

   arb_st_t                    state_q, state_d;
   port_idx_t                  rr_q, rr_d;
   port_idx_t                  gnt_q, gnt_d;
   logic                       m_ar_valid_q, m_ar_valid_d;
   logic [ADDR_BITS-1:0]       m_ar_addr_q, m_ar_addr_d;
   logic [BURST_LEN_WIDTH-1:0] m_ar_len_q, m_ar_len_d;
   logic [TID_WIDTH-1:0]       m_ar_id_q, m_ar_id_d;
   logic                       err_q, err_d;

   logic                       s0_ar_ready_c;
   logic                       s1_ar_ready_c;
   logic                       any_valid;
   port_idx_t                  win;
   logic                       push;
   logic                       pop;
   port_idx_t                  head;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic                       non_empty;
   logic [DATA_WIDTH-1:0]      r_data_w;

   axi_rd_order_fifo #(
      .LOG_DEPTH (LOG_OUTSTANDING)
   ) u_order_fifo (
      .clk    (clk),
      .resetN (resetN),
      .push   (push),
      .din    (gnt_q),
      .pop    (pop),
      .head   (head),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .count  (outstandingCnt)
   );

   // ---------------- AR arbitration ----------------
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      gnt_d         = gnt_q;
      m_ar_valid_d  = m_ar_valid_q;
      m_ar_addr_d   = m_ar_addr_q;
      m_ar_len_d    = m_ar_len_q;
      m_ar_id_d     = m_ar_id_q;
      s0_ar_ready_c = 1'b0;
      s1_ar_ready_c = 1'b0;
      push          = 1'b0;

      any_valid = s0.ar_valid | s1.ar_valid;
      // rr_q names the preferred port; fall back to the other one if idle.
      if (rr_q == PORT1) begin
         win = s1.ar_valid ? PORT1 : PORT0;
      end else begin
         win = s0.ar_valid ? PORT0 : PORT1;
      end

      case (state_q)
         ARB_IDLE: begin
            // resetN gating keeps the combinational readies low while held in reset.
            if (resetN && en && !fifo_full && any_valid) begin
               state_d      = ARB_ISSUE;
               m_ar_valid_d = 1'b1;
               gnt_d        = win;
               if (win == PORT0) begin
                  s0_ar_ready_c = 1'b1;
                  m_ar_addr_d   = s0.ar_addr;
                  m_ar_len_d    = s0.ar_len;
                  m_ar_id_d     = s0.ar_id;
               end else begin
                  s1_ar_ready_c = 1'b1;
                  m_ar_addr_d   = s1.ar_addr;
                  m_ar_len_d    = s1.ar_len;
                  m_ar_id_d     = s1.ar_id;
               end
            end
         end
         ARB_ISSUE: begin
            if (m.ar_ready) begin
               push         = 1'b1;
               rr_d         = other_port(gnt_q);
               m_ar_valid_d = 1'b0;
               state_d      = ARB_IDLE;
            end
         end
         default: begin
            state_d      = ARB_IDLE;
            m_ar_valid_d = 1'b0;
         end
      endcase
   end

   // ---------------- R steering ----------------
   // The beat is only presented to, and accepted from, the owner of the
   // oldest outstanding burst. With nothing outstanding the beat is left
   // unconsumed and flagged.
   always_comb begin
      non_empty = ~fifo_empty;
      pop       = 1'b0;
      err_d     = err_q | (m.r_valid & fifo_empty);
      if (m.r_valid && m.r_ready && m.r_last) begin
         pop = 1'b1;
      end
   end

   assign r_data_w   = m.r_data;

   assign s0.r_valid = m.r_valid & non_empty & (head == PORT0);
   assign s1.r_valid = m.r_valid & non_empty & (head == PORT1);
   assign m.r_ready  = non_empty & ((head == PORT0) ? s0.r_ready : s1.r_ready);

   assign s0.r_data  = r_data_w;
   assign s0.r_last  = m.r_last;
   assign s0.r_id    = m.r_id;
   assign s1.r_data  = r_data_w;
   assign s1.r_last  = m.r_last;
   assign s1.r_id    = m.r_id;

   assign s0.ar_ready = s0_ar_ready_c;
   assign s1.ar_ready = s1_ar_ready_c;

   assign m.ar_valid  = m_ar_valid_q;
   assign m.ar_addr   = m_ar_addr_q;
   assign m.ar_len    = m_ar_len_q;
   assign m.ar_id     = m_ar_id_q;

   assign errUnexpected = err_q;
   assign dbg_state     = state_q;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q      <= ARB_IDLE;
         rr_q         <= PORT0;
         gnt_q        <= PORT0;
         m_ar_valid_q <= 1'b0;
         m_ar_addr_q  <= '0;
         m_ar_len_q   <= '0;
         m_ar_id_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         gnt_q        <= gnt_d;
         m_ar_valid_q <= m_ar_valid_d;
         m_ar_addr_q  <= m_ar_addr_d;
         m_ar_len_q   <= m_ar_len_d;
         m_ar_id_q    <= m_ar_id_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed bench for axi_rd_arbiter with default parameters (depth 4, 8-bit
// data). Inputs change 1ns after a rising edge; outputs are read 1ns later.
// ----------------------------------------------------------------------------
module tb_axi_rd_arbiter;
   import axi_arb_pkg::*;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       en = 1'b0;
   logic [2:0] cnt;
   logic       err;
   arb_st_t    dbg;

   int checks = 0;
   int errors = 0;

   logic [0:0] exp_q[$];

   typedef struct {
      logic mv;
      logic r0;
      logic r1;
      logic e0;
      logic e1;
      logic emr;
   } rvec_t;
   rvec_t tbl[7];

   axi_rd_arbiter_if #(.ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(8), .DATA_WIDTH(8)) s0_if ();
   axi_rd_arbiter_if #(.ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(8), .DATA_WIDTH(8)) s1_if ();
   axi_rd_arbiter_if #(.ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(8), .DATA_WIDTH(8)) m_if ();

   axi_rd_arbiter #(
      .ADDR_BITS            (64),
      .BURST_LEN_WIDTH      (8),
      .TID_WIDTH            (8),
      .LOG_BLOCK_DATA_BYTES (0),
      .LOG_OUTSTANDING      (2)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .en             (en),
      .s0             (s0_if),
      .s1             (s1_if),
      .m              (m_if),
      .outstandingCnt (cnt),
      .errUnexpected  (err),
      .dbg_state      (dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, time=%0t", $time);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      s0_if.ar_valid = 1'b0; s0_if.ar_addr = '0; s0_if.ar_len = '0; s0_if.ar_id = '0; s0_if.r_ready = 1'b0;
      s1_if.ar_valid = 1'b0; s1_if.ar_addr = '0; s1_if.ar_len = '0; s1_if.ar_id = '0; s1_if.r_ready = 1'b0;
      m_if.ar_ready = 1'b0; m_if.r_valid = 1'b0; m_if.r_data = '0; m_if.r_last = 1'b0; m_if.r_id = '0;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      idle_inputs();
      step();
      step();
      resetN = 1'b1;
   endtask

   task automatic r_beat(input logic [7:0] data, input logic last, input logic [7:0] id);
      m_if.r_valid = 1'b1;
      m_if.r_data  = data;
      m_if.r_last  = last;
      m_if.r_id    = id;
   endtask

   // ---------------- test ----------------
   initial begin
      logic [0:0] p;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // ---- reset state ----
      idle_inputs();
      resetN = 1'b0;
      step();
      step();
      #1;
      chk("rst_s0_ar_ready", 64'(s0_if.ar_ready), 64'd0);
      chk("rst_s1_ar_ready", 64'(s1_if.ar_ready), 64'd0);
      chk("rst_m_ar_valid",  64'(m_if.ar_valid),  64'd0);
      chk("rst_m_ar_addr",   m_if.ar_addr,        64'd0);
      chk("rst_m_ar_len",    64'(m_if.ar_len),    64'd0);
      chk("rst_m_ar_id",     64'(m_if.ar_id),     64'd0);
      chk("rst_m_r_ready",   64'(m_if.r_ready),   64'd0);
      chk("rst_s0_r_valid",  64'(s0_if.r_valid),  64'd0);
      chk("rst_s1_r_valid",  64'(s1_if.r_valid),  64'd0);
      chk("rst_cnt",         64'(cnt),            64'd0);
      chk("rst_err",         64'(err),            64'd0);
      resetN = 1'b1;
      en     = 1'b1;

      // ---- single request ----
      step();
      s0_if.ar_valid = 1'b1; s0_if.ar_addr = 64'h10; s0_if.ar_len = 8'd3; s0_if.ar_id = 8'd5;
      m_if.ar_ready  = 1'b1;
      #1;
      chk("single_s0_ar_ready_T", 64'(s0_if.ar_ready), 64'd1);
      chk("single_s1_ar_ready_T", 64'(s1_if.ar_ready), 64'd0);
      chk("single_m_ar_valid_T",  64'(m_if.ar_valid),  64'd0);
      step();
      s0_if.ar_valid = 1'b0;
      #1;
      chk("single_m_ar_valid_T1", 64'(m_if.ar_valid), 64'd1);
      chk("single_m_ar_addr",     m_if.ar_addr,       64'h10);
      chk("single_m_ar_len",      64'(m_if.ar_len),   64'd3);
      chk("single_m_ar_id",       64'(m_if.ar_id),    64'd5);
      chk("single_dbg_issue",     64'(dbg),           64'(ARB_ISSUE));
      chk("single_cnt_pre",       64'(cnt),           64'd0);
      step();
      #1;
      chk("single_m_ar_valid_done", 64'(m_if.ar_valid), 64'd0);
      chk("single_cnt_1",           64'(cnt),           64'd1);
      s0_if.r_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r_beat(8'hA0 + 8'(i), (i == 3), 8'd5);
         #1;
         chk("single_s0_r_valid", 64'(s0_if.r_valid), 64'd1);
         chk("single_s0_r_data",  64'(s0_if.r_data),  64'hA0 + 64'(i));
         chk("single_s0_r_last",  64'(s0_if.r_last),  (i == 3) ? 64'd1 : 64'd0);
         chk("single_s1_r_valid", 64'(s1_if.r_valid), 64'd0);
         chk("single_m_r_ready",  64'(m_if.r_ready),  64'd1);
         if (i == 0) chk("single_s0_r_id", 64'(s0_if.r_id), 64'd5);
         step();
      end
      m_if.r_valid = 1'b0;
      #1;
      chk("single_cnt_0", 64'(cnt), 64'd0);

      // ---- contention and full ----
      do_reset();
      m_if.ar_ready  = 1'b1;
      s0_if.ar_valid = 1'b1; s0_if.ar_addr = 64'h100; s0_if.ar_len = 8'd1; s0_if.ar_id = 8'h20;
      s1_if.ar_valid = 1'b1; s1_if.ar_addr = 64'h200; s1_if.ar_len = 8'd1; s1_if.ar_id = 8'h21;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("cont_s0_ar_ready", 64'(s0_if.ar_ready), (g % 2 == 0) ? 64'd1 : 64'd0);
         chk("cont_s1_ar_ready", 64'(s1_if.ar_ready), (g % 2 == 1) ? 64'd1 : 64'd0);
         exp_q.push_back(1'((g % 2)));
         step();
         #1;
         chk("cont_m_ar_addr",  m_if.ar_addr, (g % 2 == 0) ? 64'h100 : 64'h200);
         chk("cont_no_grant_issue", 64'(s0_if.ar_ready | s1_if.ar_ready), 64'd0);
         step();
      end
      #1;
      chk("full_cnt_4",       64'(cnt), 64'd4);
      chk("full_no_grant_a",  64'(s0_if.ar_ready | s1_if.ar_ready), 64'd0);
      step();
      #1;
      chk("full_no_grant_b",  64'(s0_if.ar_ready | s1_if.ar_ready), 64'd0);
      // first burst (port 0) drains while both requesters still wait
      p = exp_q.pop_front();
      s0_if.r_ready = 1'b1;
      s1_if.r_ready = 1'b1;
      r_beat(8'h30, 1'b0, 8'h20);
      #1;
      chk("full_b0_s0_r_valid", 64'(s0_if.r_valid), p == 1'b0 ? 64'd1 : 64'd0);
      chk("full_b0_s1_r_valid", 64'(s1_if.r_valid), p == 1'b1 ? 64'd1 : 64'd0);
      step();
      r_beat(8'h31, 1'b1, 8'h20);
      #1;
      chk("full_pop_cycle_no_grant", 64'(s0_if.ar_ready | s1_if.ar_ready), 64'd0);
      step();
      m_if.r_valid = 1'b0;
      #1;
      chk("full_after_pop_cnt",      64'(cnt),             64'd3);
      chk("full_after_pop_s0_grant", 64'(s0_if.ar_ready),  64'd1);
      chk("full_after_pop_s1_grant", 64'(s1_if.ar_ready),  64'd0);
      exp_q.push_back(1'b0);
      step();
      s0_if.ar_valid = 1'b0;
      s1_if.ar_valid = 1'b0;
      #1;
      chk("full_regrant_addr", m_if.ar_addr, 64'h100);
      step();
      #1;
      chk("full_cnt_back_4", 64'(cnt), 64'd4);
      for (int k = 0; k < 4; k++) begin
         p = exp_q.pop_front();
         for (int b = 0; b < 2; b++) begin
            r_beat(8'h40 + 8'(k * 2 + b), (b == 1), 8'h20 + 8'(p));
            #1;
            chk("order_s0_r_valid", 64'(s0_if.r_valid), p == 1'b0 ? 64'd1 : 64'd0);
            chk("order_s1_r_valid", 64'(s1_if.r_valid), p == 1'b1 ? 64'd1 : 64'd0);
            chk("order_r_data", 64'(p == 1'b0 ? s0_if.r_data : s1_if.r_data), 64'h40 + 64'(k * 2 + b));
            step();
         end
      end
      m_if.r_valid = 1'b0;
      #1;
      chk("order_cnt_0", 64'(cnt), 64'd0);

      // ---- AR backpressure ----
      do_reset();
      m_if.ar_ready  = 1'b0;
      s1_if.ar_valid = 1'b1; s1_if.ar_addr = 64'h300; s1_if.ar_len = 8'd0; s1_if.ar_id = 8'h33;
      #1;
      chk("bp_s1_ar_ready", 64'(s1_if.ar_ready), 64'd1);
      chk("bp_s0_ar_ready", 64'(s0_if.ar_ready), 64'd0);
      step();
      s1_if.ar_valid = 1'b0;
      s0_if.ar_valid = 1'b1; s0_if.ar_addr = 64'h400; s0_if.ar_len = 8'd0; s0_if.ar_id = 8'h44;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_m_ar_valid_hold", 64'(m_if.ar_valid), 64'd1);
         chk("bp_m_ar_addr_hold",  m_if.ar_addr,       64'h300);
         chk("bp_m_ar_id_hold",    64'(m_if.ar_id),    64'h33);
         chk("bp_no_grant",        64'(s0_if.ar_ready), 64'd0);
         step();
      end
      m_if.ar_ready = 1'b1;
      #1;
      chk("bp_hs_cycle_no_grant", 64'(s0_if.ar_ready), 64'd0);
      step();
      #1;
      chk("bp_rr_s0_grant", 64'(s0_if.ar_ready), 64'd1);
      chk("bp_cnt_1",       64'(cnt),            64'd1);
      step();
      s0_if.ar_valid = 1'b0;
      step();
      #1;
      chk("bp_cnt_2", 64'(cnt), 64'd2);

      // ---- R routing table, head owned by port 1, no last beat ----
      step();
      m_if.r_last = 1'b0; m_if.r_id = 8'h33; m_if.r_data = 8'h55;
      for (int v = 0; v < 7; v++) begin
         m_if.r_valid  = tbl[v].mv;
         s0_if.r_ready = tbl[v].r0;
         s1_if.r_ready = tbl[v].r1;
         #1;
         chk("tbl_s0_r_valid", 64'(s0_if.r_valid), 64'(tbl[v].e0));
         chk("tbl_s1_r_valid", 64'(s1_if.r_valid), 64'(tbl[v].e1));
         chk("tbl_m_r_ready",  64'(m_if.r_ready),  64'(tbl[v].emr));
      end
      chk("tbl_cnt_2", 64'(cnt), 64'd2);

      // ---- R backpressure on port 1 ----
      step();
      s0_if.r_ready = 1'b1;
      s1_if.r_ready = 1'b0;
      r_beat(8'h55, 1'b1, 8'h33);
      #1;
      chk("rbp_m_r_ready",  64'(m_if.r_ready),  64'd0);
      chk("rbp_s1_r_valid", 64'(s1_if.r_valid), 64'd1);
      step();
      #1;
      chk("rbp_cnt_hold",   64'(cnt),           64'd2);
      chk("rbp_s1_r_still", 64'(s1_if.r_valid), 64'd1);
      s1_if.r_ready = 1'b1;
      #1;
      chk("rbp_m_r_ready_1", 64'(m_if.r_ready), 64'd1);
      chk("rbp_s1_r_data",   64'(s1_if.r_data), 64'h55);
      step();
      #1;
      chk("rbp_cnt_1", 64'(cnt), 64'd1);
      r_beat(8'h66, 1'b1, 8'h44);
      #1;
      chk("rbp_s0_r_valid", 64'(s0_if.r_valid), 64'd1);
      chk("rbp_s1_r_idle",  64'(s1_if.r_valid), 64'd0);
      chk("rbp_s0_r_id",    64'(s0_if.r_id),    64'h44);
      step();
      m_if.r_valid = 1'b0;
      #1;
      chk("rbp_cnt_0", 64'(cnt), 64'd0);

      // ---- enable ----
      do_reset();
      en = 1'b0;
      m_if.ar_ready  = 1'b0;
      s0_if.ar_valid = 1'b1; s0_if.ar_addr = 64'h500; s0_if.ar_len = 8'd1; s0_if.ar_id = 8'h55;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("en0_no_grant", 64'(s0_if.ar_ready), 64'd0);
         step();
      end
      en = 1'b1;
      #1;
      chk("en1_grant", 64'(s0_if.ar_ready), 64'd1);
      step();
      en = 1'b0;
      #1;
      chk("en_drop_m_ar_valid", 64'(m_if.ar_valid), 64'd1);
      step();
      m_if.ar_ready = 1'b1;
      step();
      #1;
      chk("en_drop_cnt_1",   64'(cnt),            64'd1);
      chk("en_drop_no_grant", 64'(s0_if.ar_ready), 64'd0);
      s0_if.r_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         r_beat(8'h70 + 8'(b), (b == 1), 8'h55);
         #1;
         chk("en_drop_s0_r_valid", 64'(s0_if.r_valid), 64'd1);
         chk("en_drop_s0_r_data",  64'(s0_if.r_data),  64'h70 + 64'(b));
         step();
      end
      m_if.r_valid = 1'b0;
      #1;
      chk("en_drop_cnt_0",     64'(cnt),            64'd0);
      chk("en_drop_still_off", 64'(s0_if.ar_ready), 64'd0);

      // ---- unexpected R beat ----
      s0_if.ar_valid = 1'b0;
      r_beat(8'h99, 1'b1, 8'h00);
      #1;
      chk("unexp_m_r_ready",  64'(m_if.r_ready),  64'd0);
      chk("unexp_s0_r_valid", 64'(s0_if.r_valid), 64'd0);
      chk("unexp_s1_r_valid", 64'(s1_if.r_valid), 64'd0);
      chk("unexp_err_before", 64'(err),           64'd0);
      step();
      #1;
      chk("unexp_err_set", 64'(err), 64'd1);
      m_if.r_valid = 1'b0;
      step();
      step();
      #1;
      chk("unexp_err_sticky", 64'(err), 64'd1);
      chk("unexp_cnt_0",      64'(cnt), 64'd0);
      do_reset();
      #1;
      chk("unexp_err_cleared", 64'(err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
